// File: rtl/qnm_fifo.sv
// qnm_fifo: circular FIFO whose entries carry an immutable payload (N) and a
// mutable metadata field (M). Every slot's M is exported flat so surrounding
// logic can rewrite any subset of slots in place (tag match, retire/flush).
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   wr            enqueue {n_din, m_din} at tail (ignored when full)
//   rd            dequeue head entry (ignored when empty)
//   n_din         payload for enqueue
//   m_din         metadata for enqueue
//   modify_vector bit i set: overwrite M of physical slot i
//   new_m_vector  replacement M values, slot i at [i*M_WIDTH +: M_WIDTH]
//   old_m_vector  stored M of every physical slot, same packing
//   dout          head entry {N, M}, N in the MSBs
//   full          occupancy == Q_LENGTH
//   empty         occupancy == 0
module qnm_fifo #(
    parameter int N_WIDTH  = 32,
    parameter int M_WIDTH  = 8,
    parameter int Q_LENGTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [N_WIDTH-1:0]           n_din,
    input  logic [M_WIDTH-1:0]           m_din,
    input  logic [Q_LENGTH-1:0]          modify_vector,
    input  logic [M_WIDTH*Q_LENGTH-1:0]  new_m_vector,
    output logic [M_WIDTH*Q_LENGTH-1:0]  old_m_vector,
    output logic [N_WIDTH+M_WIDTH-1:0]   dout,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(Q_LENGTH);
    localparam int CNT_W = $clog2(Q_LENGTH + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(Q_LENGTH - 1);

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N_WIDTH-1:0] n_mem_q [Q_LENGTH];
    logic [M_WIDTH-1:0] m_mem_q [Q_LENGTH];

    logic               wr_ok;
    logic               rd_ok;
    logic [Q_LENGTH-1:0] slot_we;

    assign full  = (count_q == CNT_W'(Q_LENGTH));
    assign empty = (count_q == '0);

    // Accept qualifiers; a write while full is dropped even if a read
    // would free a slot in the same cycle.
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    // Pointers wrap explicitly so Q_LENGTH need not be a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rd_ok) begin
            head_d = (head_q == LAST_SLOT) ? '0 : head_q + 1'b1;
        end
        if (wr_ok) begin
            tail_d = (tail_q == LAST_SLOT) ? '0 : tail_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Per-slot write enables and flat export of the M fields.
    generate
        for (genvar gi = 0; gi < Q_LENGTH; gi++) begin : g_slot
            assign slot_we[gi] = wr_ok && (tail_q == PTR_W'(gi));
            assign old_m_vector[gi*M_WIDTH +: M_WIDTH] = m_mem_q[gi];
        end
    endgenerate

    // Enqueue into a slot wins over an in-place modify of the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Q_LENGTH; i++) begin
                n_mem_q[i] <= '0;
                m_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Q_LENGTH; i++) begin
                if (slot_we[i]) begin
                    n_mem_q[i] <= n_din;
                    m_mem_q[i] <= m_din;
                end else if (modify_vector[i]) begin
                    m_mem_q[i] <= new_m_vector[i*M_WIDTH +: M_WIDTH];
                end
            end
        end
    end

    assign dout = {n_mem_q[head_q], m_mem_q[head_q]};

endmodule

// File: tb/tb_qnm_fifo.sv
module tb_qnm_fifo;

    localparam int NW = 32;
    localparam int MW = 8;
    localparam int Q  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr = 1'b0;
    logic            rd = 1'b0;
    logic [NW-1:0]   n_din = '0;
    logic [MW-1:0]   m_din = '0;
    logic [Q-1:0]    modify_vector = '0;
    logic [MW*Q-1:0] new_m_vector = '0;
    logic [MW*Q-1:0] old_m_vector;
    logic [NW+MW-1:0] dout;
    logic            full;
    logic            empty;

    int checks = 0;
    int errors = 0;

    // Reference model: physical slot contents, head index and occupancy.
    logic [NW-1:0] mod_n [Q];
    logic [MW-1:0] mod_m [Q];
    int            mod_head;
    int            mod_count;

    qnm_fifo #(.N_WIDTH(NW), .M_WIDTH(MW), .Q_LENGTH(Q)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .n_din        (n_din),
        .m_din        (m_din),
        .modify_vector(modify_vector),
        .new_m_vector (new_m_vector),
        .old_m_vector (old_m_vector),
        .dout         (dout),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < Q; i++) begin
            mod_n[i] = '0;
            mod_m[i] = '0;
        end
        mod_head  = 0;
        mod_count = 0;
    endtask

    task automatic model_step(input bit r, input bit w, input bit d,
                              input logic [NW-1:0] n, input logic [MW-1:0] m,
                              input logic [Q-1:0] mv, input logic [MW*Q-1:0] nm);
        bit w_acc;
        bit r_acc;
        int tail;
        if (r) begin
            model_clear();
        end else begin
            w_acc = w && (mod_count < Q);
            r_acc = d && (mod_count > 0);
            tail  = (mod_head + mod_count) % Q;
            for (int i = 0; i < Q; i++)
                if (mv[i]) mod_m[i] = nm[i*MW +: MW];
            if (w_acc) begin
                mod_n[tail] = n;
                mod_m[tail] = m;
            end
            if (r_acc) mod_head = (mod_head + 1) % Q;
            mod_count = mod_count + int'(w_acc) - int'(r_acc);
        end
    endtask

    task automatic check_outputs();
        logic [MW*Q-1:0] exp_old;
        for (int i = 0; i < Q; i++) exp_old[i*MW +: MW] = mod_m[i];
        chk("empty", 64'(empty), 64'(mod_count == 0));
        chk("full", 64'(full), 64'(mod_count == Q));
        chk("dout", 64'(dout), 64'({mod_n[mod_head], mod_m[mod_head]}));
        chk("old_m_vector", 64'(old_m_vector), 64'(exp_old));
    endtask

    // One clock: drive after the falling edge, check 1 time unit after the rising edge.
    task automatic step(input bit r, input bit w, input bit d,
                        input logic [NW-1:0] n, input logic [MW-1:0] m,
                        input logic [Q-1:0] mv, input logic [MW*Q-1:0] nm);
        @(negedge clk);
        rst = r; wr = w; rd = d; n_din = n; m_din = m;
        modify_vector = mv; new_m_vector = nm;
        @(posedge clk);
        model_step(r, w, d, n, m, mv, nm);
        #1;
        check_outputs();
        $display("t=%0t rst=%0b wr=%0b rd=%0b n=%h m=%h mv=%b cnt=%0d dout=%h",
                 $time, r, w, d, n, m, mv, mod_count, dout);
    endtask

    task automatic do_write(input logic [NW-1:0] n, input logic [MW-1:0] m);
        step(1'b0, 1'b1, 1'b0, n, m, '0, '0);
    endtask

    task automatic do_read();
        step(1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    endtask

    initial begin
        logic [MW*Q-1:0] nm;
        model_clear();

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_old_m", 64'(old_m_vector), 64'd0);

        // Three writes then three reads
        do_write(32'h11, 8'h01);
        do_write(32'h22, 8'h02);
        do_write(32'h33, 8'h03);
        chk("first_head", 64'(dout), 64'({32'h11, 8'h01}));
        chk("old_m_0to2", 64'(old_m_vector[23:0]), 64'h030201);
        do_read();
        chk("second_head", 64'(dout), 64'({32'h22, 8'h02}));
        do_read();
        chk("third_head", 64'(dout), 64'({32'h33, 8'h03}));
        do_read();
        chk("empty_after_3", 64'(empty), 64'd1);

        // Fill, overflow attempts, drain, refill across the wrap
        for (int i = 0; i < Q; i++) do_write(32'h100 + 32'(i), 8'(i));
        chk("full_after_fill", 64'(full), 64'd1);
        do_write(32'hDEAD, 8'hEE);
        step(1'b0, 1'b1, 1'b1, 32'hBEEF, 8'hEF, '0, '0);
        chk("wr_rd_full_count", 64'(full), 64'd0);
        for (int i = 0; i < Q - 1; i++) do_read();
        for (int i = 8; i < 16; i++) do_write(32'h100 + 32'(i), 8'(i));
        for (int i = 0; i < Q; i++) do_read();

        // In-place modify with four entries starting at slot 0
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 4; i++) do_write(32'h200 + 32'(i), 8'h10 + 8'(i));
        nm = '0;
        nm[0*MW +: MW] = 8'hAA;
        nm[2*MW +: MW] = 8'hBB;
        nm[1*MW +: MW] = 8'h77;
        step(1'b0, 1'b0, 1'b0, '0, '0, 8'b0000_0101, nm);
        chk("mod_slot0", 64'(old_m_vector[7:0]), 64'hAA);
        chk("mod_slot1_kept", 64'(old_m_vector[15:8]), 64'h11);
        chk("mod_slot2", 64'(old_m_vector[23:16]), 64'hBB);
        chk("mod_dout_m", 64'(dout[7:0]), 64'hAA);

        // Write and modify of the same slot: the write wins
        nm = '0;
        nm[4*MW +: MW] = 8'h99;
        step(1'b0, 1'b1, 1'b0, 32'h204, 8'h55, 8'b0001_0000, nm);
        chk("wr_beats_mod", 64'(old_m_vector[39:32]), 64'h55);

        // Drain to two entries, then simultaneous read+write
        for (int i = 0; i < 3; i++) do_read();
        step(1'b0, 1'b1, 1'b1, 32'h205, 8'h56, '0, '0);
        for (int i = 0; i < 3; i++) do_read();

        // Read on empty, write+read on empty
        do_read();
        step(1'b0, 1'b1, 1'b1, 32'h300, 8'h30, '0, '0);
        chk("wr_rd_empty_head", 64'(dout), 64'({32'h300, 8'h30}));
        do_read();

        // Reset with five occupied and a write pending
        for (int i = 0; i < 5; i++) do_write(32'h400 + 32'(i), 8'h40 + 8'(i));
        step(1'b1, 1'b1, 1'b0, 32'h4FF, 8'h4F, 8'hFF, '1);
        chk("rst_mid_empty", 64'(empty), 64'd1);
        chk("rst_mid_dout", 64'(dout), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 5),
                 $urandom, 8'($urandom),
                 8'($urandom & $urandom & $urandom),
                 {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
